// File: rtl/pf_vf_mux_pkg.sv
// Shared types for the PF/VF stream mux/merge blocks: port tag layout,
// arbiter states and the platform's default port-to-function tables.
package pf_vf_mux_pkg;

  typedef struct packed {
    logic [2:0]  pf;
    logic [10:0] vf;
    logic        vf_active;
  } pfvf_tag_t;

  localparam int TAG_W = $bits(pfvf_tag_t);

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Platform map: port 0 -> PF0, port 1 -> PF1, no virtual functions.
  localparam int          PLAT_NUM_PORT                       = 2;
  localparam logic [2:0]  PLAT_PF_NUM_TABLE    [PLAT_NUM_PORT] = '{3'd0, 3'd1};
  localparam logic [10:0] PLAT_VF_NUM_TABLE    [PLAT_NUM_PORT] = '{11'd0, 11'd0};
  localparam logic        PLAT_VF_ACTIVE_TABLE [PLAT_NUM_PORT] = '{1'b0, 1'b0};

  function automatic pfvf_tag_t make_tag(input logic [2:0] pf, input logic [10:0] vf,
                                         input logic vf_active);
    pfvf_tag_t t;
    t.pf        = pf;
    t.vf        = vf;
    t.vf_active = vf_active;
    return t;
  endfunction

endpackage

// File: rtl/pfvf_tx_skid.sv
// Two-entry output buffer: a registered output stage plus one skid slot, so
// the upstream ready depends only on flops and full throughput is kept.
module pfvf_tx_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_vld_r;
  logic [W-1:0] out_dat_r;
  logic         skid_vld_r;
  logic [W-1:0] skid_dat_r;
  logic         push_s;
  logic         load_s;

  assign in_ready  = ~skid_vld_r;
  assign push_s    = in_valid & ~skid_vld_r;
  assign load_s    = out_ready | ~out_vld_r;
  assign out_valid = out_vld_r;
  assign out_data  = out_dat_r;

  // Output stage refills from the skid slot first; the skid slot only fills
  // while the output stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_r  <= 1'b0;
      out_dat_r  <= '0;
      skid_vld_r <= 1'b0;
      skid_dat_r <= '0;
    end else if (load_s) begin
      if (skid_vld_r) begin
        out_dat_r  <= skid_dat_r;
        out_vld_r  <= 1'b1;
        skid_vld_r <= 1'b0;
      end else if (push_s) begin
        out_dat_r <= in_data;
        out_vld_r <= 1'b1;
      end else begin
        out_vld_r <= 1'b0;
      end
    end else if (push_s) begin
      skid_dat_r <= in_data;
      skid_vld_r <= 1'b1;
    end else begin
      skid_vld_r <= skid_vld_r;
    end
  end

endmodule

// File: rtl/pfvf_tx_merge.sv
// Merges NUM_PORT AXI-S TX sources into one host stream, packet-atomic
// round-robin, tagging each beat with its source port's PF/VF identity.
module pfvf_tx_merge
  import pf_vf_mux_pkg::*;
#(
  parameter int          NUM_PORT                         = PLAT_NUM_PORT,
  parameter int          DATA_W                           = 512,
  parameter logic [2:0]  PF_NUM_TABLE    [NUM_PORT]       = PLAT_PF_NUM_TABLE,
  parameter logic [10:0] VF_NUM_TABLE    [NUM_PORT]       = PLAT_VF_NUM_TABLE,
  parameter logic        VF_ACTIVE_TABLE [NUM_PORT]       = PLAT_VF_ACTIVE_TABLE,
  localparam int         PID_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORT-1:0]        s_tvalid,
  output logic [NUM_PORT-1:0]        s_tready,
  input  logic [NUM_PORT*DATA_W-1:0] s_tdata,
  input  logic [NUM_PORT-1:0]        s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tlast,
  output logic [PID_W-1:0]           m_port_id,
  output logic [2:0]                 m_pf_num,
  output logic [10:0]                m_vf_num,
  output logic                       m_vf_active,
  output logic [NUM_PORT*16-1:0]     pkt_cnt
);

  localparam int               PAY_W     = DATA_W + 1 + PID_W + TAG_W;
  localparam logic [PID_W-1:0] LAST_PORT = PID_W'(NUM_PORT - 1);

  arb_state_t        state_r, state_nxt_s;
  logic [PID_W-1:0]  lock_port_r, lock_port_nxt_s;
  logic [PID_W-1:0]  rr_ptr_r, rr_ptr_nxt_s;
  logic [PID_W-1:0]  grant_s;
  logic              grant_vld_s;
  int                best_dist_s;
  logic              run_r;
  logic              skid_ready_s;
  logic              xfer_s;
  logic              beat_last_s;
  logic [DATA_W-1:0] beat_data_s;
  pfvf_tag_t         tag_in_s, tag_out_s;
  logic [PAY_W-1:0]  pay_in_s, pay_out_s;
  logic [15:0]       cnt_r [NUM_PORT];

  function automatic int rr_dist(input int p, input int rr);
    return (p >= rr) ? (p - rr) : (p + NUM_PORT - rr);
  endfunction

  // Grant: the locked port, or the nearest valid port at/after rr_ptr.
  always_comb begin
    grant_s     = lock_port_r;
    grant_vld_s = 1'b0;
    best_dist_s = NUM_PORT;
    if (state_r == ARB_LOCKED) begin
      grant_vld_s = 1'b1;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        if (s_tvalid[p] && (rr_dist(p, int'(rr_ptr_r)) < best_dist_s)) begin
          best_dist_s = rr_dist(p, int'(rr_ptr_r));
          grant_s     = PID_W'(p);
          grant_vld_s = 1'b1;
        end else begin
          best_dist_s = best_dist_s;
        end
      end
    end
  end

  // Steer the granted port's beat; ready is withheld until out of reset.
  always_comb begin
    s_tready    = '0;
    beat_data_s = '0;
    beat_last_s = 1'b0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (grant_s == PID_W'(p)) begin
        s_tready[p] = run_r & grant_vld_s & skid_ready_s;
        beat_data_s = s_tdata[p*DATA_W +: DATA_W];
        beat_last_s = s_tlast[p];
      end else begin
        s_tready[p] = 1'b0;
      end
    end
  end

  assign xfer_s   = |(s_tvalid & s_tready);
  assign tag_in_s = make_tag(PF_NUM_TABLE[grant_s], VF_NUM_TABLE[grant_s],
                             VF_ACTIVE_TABLE[grant_s]);
  assign pay_in_s = {beat_data_s, beat_last_s, grant_s, tag_in_s};

  // Arbiter next state; a tlast acceptance always ends the lock and moves rr_ptr.
  always_comb begin
    state_nxt_s     = state_r;
    lock_port_nxt_s = lock_port_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s && !beat_last_s) begin
          state_nxt_s     = ARB_LOCKED;
          lock_port_nxt_s = grant_s;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (xfer_s && beat_last_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_LOCKED;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
    if (xfer_s && beat_last_s) begin
      rr_ptr_nxt_s = (grant_s == LAST_PORT) ? '0 : grant_s + PID_W'(1);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ARB_IDLE;
      lock_port_r <= '0;
      rr_ptr_r    <= '0;
      run_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lock_port_r <= lock_port_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      run_r       <= 1'b1;
    end
  end

  pfvf_tx_skid #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (xfer_s),
    .in_ready  (skid_ready_s),
    .in_data   (pay_in_s),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (pay_out_s)
  );

  assign {m_tdata, m_tlast, m_port_id, tag_out_s} = pay_out_s;
  assign m_pf_num    = tag_out_s.pf;
  assign m_vf_num    = tag_out_s.vf;
  assign m_vf_active = tag_out_s.vf_active;

  // Completed-packet counters, counted as tlast beats leave on the host side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORT; p++) cnt_r[p] <= 16'd0;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        if (m_tvalid && m_tready && m_tlast && (m_port_id == PID_W'(p))) begin
          cnt_r[p] <= cnt_r[p] + 16'd1;
        end else begin
          cnt_r[p] <= cnt_r[p];
        end
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int p = 0; p < NUM_PORT; p++) pkt_cnt[p*16 +: 16] = cnt_r[p];
  end

endmodule

// File: tb/tb_pfvf_tx_merge.sv
// Self-checking bench for pfvf_tx_merge: vector table, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_pfvf_tx_merge;

  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      s_tvalid, s_tready, s_tlast;
  logic [2*DW-1:0] s_tdata;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [0:0]      m_port_id;
  logic [2:0]      m_pf_num;
  logic [10:0]     m_vf_num;
  logic            m_vf_active;
  logic [31:0]     pkt_cnt;

  int checks = 0;
  int errors = 0;

  pfvf_tx_merge dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_port_id(m_port_id), .m_pf_num(m_pf_num), .m_vf_num(m_vf_num),
    .m_vf_active(m_vf_active), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic put(input int p, input logic [DW-1:0] d);
    s_tdata[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Reference model: expected beats in acceptance order, port tags, counters.
  typedef struct {logic [DW-1:0] data; logic last; int port;} beat_t;
  beat_t       exp_q[$];
  logic [2:0]  pf_tab [2] = '{3'd0, 3'd1};
  logic [10:0] vf_tab [2] = '{11'd0, 11'd0};
  logic        act_tab[2] = '{1'b0, 1'b0};
  int          mdl_rr;
  bit          mdl_in_pkt;
  int          mdl_cur;
  logic [15:0] mdl_cnt[2];
  bit          prev_stall;
  logic [DW-1:0] prev_data;
  logic        prev_last;
  logic [0:0]  prev_pid;

  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      exp_q.delete();
      mdl_rr = 0; mdl_in_pkt = 0; mdl_cur = 0;
      mdl_cnt[0] = 16'd0; mdl_cnt[1] = 16'd0;
      prev_stall = 0;
    end else begin
      int nacc, acc_p, want;
      chk("pkt_cnt0", pkt_cnt[15:0], mdl_cnt[0]);
      chk("pkt_cnt1", pkt_cnt[31:16], mdl_cnt[1]);
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_data", m_tdata, prev_data);
        chk("hold_last", m_tlast, prev_last);
        chk("hold_port", m_port_id, prev_pid);
      end
      if (mdl_in_pkt) chk("lock_other_ready", s_tready[1-mdl_cur], 1'b0);
      nacc = 0; acc_p = 0;
      for (int p = 0; p < 2; p++)
        if (s_tvalid[p] && s_tready[p]) begin nacc++; acc_p = p; end
      if (nacc > 1) chk("multi_accept", nacc, 1);
      if (nacc == 1) begin
        if (mdl_in_pkt) want = mdl_cur;
        else want = s_tvalid[mdl_rr] ? mdl_rr : (mdl_rr + 1) % 2;
        chk("arb_port", acc_p, want);
        exp_q.push_back('{s_tdata[acc_p*DW +: DW], s_tlast[acc_p], acc_p});
        if (s_tlast[acc_p]) begin mdl_in_pkt = 0; mdl_rr = (acc_p + 1) % 2; end
        else begin mdl_in_pkt = 1; mdl_cur = acc_p; end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1'b1, 1'b0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("out_data", m_tdata, b.data);
          chk("out_last", m_tlast, b.last);
          chk("out_port", m_port_id, b.port);
          chk("out_pf", m_pf_num, pf_tab[b.port]);
          chk("out_vf", m_vf_num, vf_tab[b.port]);
          chk("out_vfact", m_vf_active, act_tab[b.port]);
          if (b.last) mdl_cnt[b.port] = mdl_cnt[b.port] + 16'd1;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata; prev_last = m_tlast; prev_pid = m_port_id;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_tvalid = 2'b00; s_tlast = 2'b00; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_s_tready"}, s_tready, 2'b00);
    chk({nm, "_m_tvalid"}, m_tvalid, 1'b0);
    chk({nm, "_m_tdata"}, m_tdata, '0);
    chk({nm, "_m_tlast"}, m_tlast, 1'b0);
    chk({nm, "_m_port_id"}, m_port_id, 1'b0);
    chk({nm, "_tags"}, {m_pf_num, m_vf_num, m_vf_active}, 15'd0);
    chk({nm, "_pkt_cnt"}, pkt_cnt, 32'd0);
  endtask

  typedef struct {logic [1:0] vld; logic [1:0] rdy;} vec_t;
  vec_t tbl[8];

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev_rdy;
    logic [1:0] exp_rdy[5];
    logic       exp_pid[4];
    int idx, n;

    rst_n = 1'b0; s_tvalid = 2'b11; s_tlast = 2'b11; s_tdata = '0; m_tready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    do_reset();

    // Vector table: single-beat packets, grant and output port per step.
    tbl[0] = '{2'b11, 2'b01}; tbl[1] = '{2'b11, 2'b10};
    tbl[2] = '{2'b10, 2'b10}; tbl[3] = '{2'b01, 2'b01};
    tbl[4] = '{2'b01, 2'b01}; tbl[5] = '{2'b00, 2'b00};
    tbl[6] = '{2'b11, 2'b10}; tbl[7] = '{2'b11, 2'b01};
    prev_rdy = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_tvalid = tbl[i].vld; s_tlast = 2'b11;
      put(0, DW'(1000 + i)); put(1, DW'(2000 + i));
      #1;
      chk("tbl_ready", s_tready, tbl[i].rdy);
      chk("tbl_mvalid", m_tvalid, prev_rdy != 2'b00);
      if (prev_rdy != 2'b00) chk("tbl_port", m_port_id, prev_rdy == 2'b10);
      prev_rdy = tbl[i].rdy;
    end

    // Port0 3-beat packet with port1 always valid: no interleave.
    do_reset();
    exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    exp_pid = '{1'b0, 1'b0, 1'b0, 1'b1};
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_tvalid = 2'b11; s_tlast = {1'b1, idx == 2};
      put(0, DW'(100 + idx)); put(1, DW'(200 + c));
      #1;
      chk("pkt3_ready", s_tready, exp_rdy[c]);
      if (c >= 1) begin
        chk("pkt3_port", m_port_id, exp_pid[c-1]);
        chk("pkt3_pf", m_pf_num, pf_tab[exp_pid[c-1]]);
      end
      if (s_tready[0]) idx++;
    end

    // Continuous single-beat packets from both ports alternate with no bubble.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      s_tvalid = 2'b11; s_tlast = 2'b11;
      put(0, DW'(400 + c)); put(1, DW'(450 + c));
      #1;
      chk("alt_ready", s_tready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (c >= 1) begin
        chk("alt_mvalid", m_tvalid, 1'b1);
        chk("alt_port", m_port_id, (c - 1) % 2);
      end
    end

    // Output stall of 5 cycles mid-packet.
    do_reset();
    idx = 0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(negedge clk);
      m_tready = !(c >= 2 && c <= 6);
      s_tvalid = 2'b01; s_tlast = {1'b0, idx == 5};
      put(0, DW'(300 + idx));
      #1;
      if (c >= 3 && c <= 6) begin
        chk("stall_ready", s_tready, 2'b00);
        chk("stall_mvalid", m_tvalid, 1'b1);
        chk("stall_data", m_tdata, DW'(301));
      end
      if (s_tready[0]) idx++;
    end
    chk("stall_sent", idx, 6);
    @(negedge clk); s_tvalid = 2'b00; m_tready = 1'b1;
    repeat (3) @(negedge clk);

    // Port1 packet with a 2-cycle valid gap; port0 waits for the tlast.
    do_reset();
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      s_tvalid[0] = (c != 0);
      s_tvalid[1] = (c == 0 || c == 1 || c == 4 || c == 5);
      s_tlast = {idx == 3, 1'b1};
      put(0, DW'(600 + c)); put(1, DW'(700 + idx));
      #1;
      chk("gap_port0_ready", s_tready[0], c == 6);
      if (s_tvalid[1] && s_tready[1]) idx++;
    end
    chk("gap_sent", idx, 4);

    // Reset during beat 2 of a 4-beat packet, then a fresh port1 packet.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_tvalid = 2'b01; s_tlast = 2'b00; put(0, DW'(800 + c));
      if (c == 2) rst_n = 1'b0;
      #1;
    end
    chk_reset_outputs("midrst");
    @(negedge clk); s_tvalid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    s_tvalid = 2'b11; s_tlast = 2'b11; put(0, DW'(900)); put(1, DW'(901));
    #1; chk("rst_rr_ready", s_tready, 2'b01);
    @(negedge clk);
    s_tvalid = 2'b10; s_tlast = 2'b00; put(1, DW'(500));
    #1; chk("rst_p1_ready", s_tready, 2'b10);
    @(negedge clk);
    s_tlast = 2'b10; put(1, DW'(501));
    #1; chk("rst_b0_data", m_tdata, DW'(500)); chk("rst_b0_port", m_port_id, 1'b1);
    chk("rst_b0_pf", m_pf_num, 3'd1);
    @(negedge clk);
    s_tvalid = 2'b00;
    #1; chk("rst_b1_data", m_tdata, DW'(501)); chk("rst_b1_last", m_tlast, 1'b1);

    // Counter wrap: 65535 port0 packets then one more; port1 holds its count.
    do_reset();
    @(negedge clk); s_tvalid = 2'b10; s_tlast = 2'b11; put(1, DW'(77));
    n = 0;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      @(negedge clk);
      s_tvalid = 2'b01; s_tlast = 2'b11; put(0, rnd_data());
      #1;
      if (s_tready[0]) n++;
    end
    chk("wrap_fill", n, 65535);
    @(negedge clk); s_tvalid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("wrap_pre0", pkt_cnt[15:0], 16'hFFFF);
    chk("wrap_pre1", pkt_cnt[31:16], 16'd1);
    @(negedge clk); s_tvalid = 2'b01; put(0, DW'(55));
    @(negedge clk); s_tvalid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("wrap_post0", pkt_cnt[15:0], 16'h0000);
    chk("wrap_post1", pkt_cnt[31:16], 16'd1);

    // Randomized traffic; the monitor checks every handshake.
    do_reset();
    begin
      int rem[2];
      logic [1:0] acc;
      rem = '{0, 0}; acc = 2'b00;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
          if (acc[p]) rem[p]--;
          if (!(s_tvalid[p] && !acc[p])) begin
            if (rem[p] == 0) rem[p] = $urandom_range(1, 4);
            s_tvalid[p] = ($urandom_range(0, 3) != 0);
            s_tlast[p]  = (rem[p] == 1);
            put(p, rnd_data());
          end
        end
        m_tready = ($urandom_range(0, 3) != 0);
        #1;
        acc = s_tvalid & s_tready;
      end
    end
    @(negedge clk); s_tvalid = 2'b00; m_tready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pfvf_tx_merge.md
PFVF_TX_MERGE -- requirements
Module: pfvf_tx_merge

Interface
REQ-001 Parameter NUM_PORT, 2, number of AFU-side TX source ports (>=2).
REQ-002 Parameter DATA_W, 512, tdata width in bits.
REQ-003 Parameter PF_NUM_TABLE, '{0,1}, per-port 3-bit PF number.
REQ-004 Parameter VF_NUM_TABLE, '{0,0}, per-port 11-bit VF number.
REQ-005 Parameter VF_ACTIVE_TABLE, '{0,0}, per-port VF-active bit.
REQ-006 The block SHALL use one clock and an asynchronous active-low reset:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- s_tvalid  in  NUM_PORT  per-port beat valid
- s_tready  out  NUM_PORT  per-port beat accept
- s_tdata  in  NUM_PORT*DATA_W  per-port data; port p at [p*DATA_W +: DATA_W]
- s_tlast  in  NUM_PORT  per-port end of packet
- m_tvalid  out  1  merged beat valid
- m_tready  in  1  host-side accept
- m_tdata  out  DATA_W  merged data
- m_tlast  out  1  merged end of packet
- m_port_id  out  $clog2(NUM_PORT)  source port of beat
- m_pf_num  out  3  PF tag of source port
- m_vf_num  out  11  VF tag of source port
- m_vf_active  out  1  VF-active tag of source port
- pkt_cnt  out  NUM_PORT*16  per-port completed-packet counters

Function
REQ-007 The block SHALL merge NUM_PORT AXI-S streams into one, the inverse of the RX PF/VF mux: port index is encoded into PF/VF tags.
REQ-008 Arbiter states: IDLE, LOCKED; LOCKED records granted port g.
REQ-009 In IDLE, the first valid port at or after rr_ptr (wrapping NUM_PORT-1 -> 0) SHALL be granted combinationally in the same cycle; no valid ports -> stay IDLE.
REQ-010 A granted beat accepted without tlast SHALL move to LOCKED(g); with tlast, stay IDLE.
REQ-011 In LOCKED(g), only port g SHALL be accepted; other ports' s_tready=0 until g's tlast beat is accepted, then IDLE.
REQ-012 On acceptance of any tlast beat from port g, rr_ptr SHALL become (g+1) mod NUM_PORT.
REQ-013 s_tready[p]=1 only if p is granted and the output buffer is not full; a beat transfers on s_tvalid[p]&s_tready[p].
REQ-014 Output buffer: 2-entry skid, registered s_tready input side; latency input acceptance -> m_tvalid = 1 cycle.
REQ-015 Back-to-back packets (different or same port) SHALL flow with zero bubble cycles when m_tready=1.
REQ-016 Every beat SHALL carry m_port_id=g and PF/VF tags from the tables at index g; tags stable on every beat of a packet.
REQ-017 m_tvalid SHALL hold, and m_tdata/m_tlast/tags SHALL stay stable, while m_tready=0.
REQ-018 pkt_cnt[g] SHALL increment by 1 when a tlast beat leaves on m_tvalid&m_tready, wrapping 16'hFFFF -> 0.
REQ-019 Single-beat packets SHALL never enter LOCKED.
REQ-020 A source dropping s_tvalid mid-packet SHALL keep the lock; no other port is served.

Reset
REQ-021 On rst_n low (async), state=IDLE, rr_ptr=0, buffer empty, m_tvalid=0, s_tready=0, m_tdata/m_tlast/m_port_id/tags=0, pkt_cnt=0.
REQ-022 Reset mid-packet SHALL discard the partial packet and buffered beats; first accepted beat after reset is treated as start of packet.
REQ-023 Outputs SHALL leave reset values only on the first clk edge after rst_n deasserts.

Structure
REQ-024 PF/VF tag typedef (pf 3b, vf 11b, vf_active 1b) and arbiter state enum SHALL live in pf_vf_mux_pkg; port tables come from the platform config package.
REQ-025 The 2-entry output buffer SHALL be a sub-module pfvf_tx_skid (parameterized payload width).

Verification
REQ-026 Port0 sends 3-beat packet, port1 valid throughout, m_tready=1 -> 3 port0 beats then port1 beats, no interleave, m_pf_num 0 then 1.
REQ-027 Both ports send single-beat packets continuously -> output alternates port 0,1,0,1 every cycle, no bubbles.
REQ-028 m_tready=0 for 5 cycles mid-packet -> m_tvalid held, data stable, s_tready=0 after buffer holds 2 beats, no loss/duplication.
REQ-029 Port1 packet with 2-cycle s_tvalid gap mid-packet while port0 valid -> port0 not granted until port1 tlast accepted.
REQ-030 Preload pkt_cnt[0] to 16'hFFFF via 65535 packets, send one more -> pkt_cnt[0]=0, pkt_cnt[1] unchanged.
REQ-031 Assert rst_n=0 during beat 2 of 4-beat packet -> all outputs reset values next cycle; after release a new packet from port1 emerges intact with rr_ptr starting at 0.
